// File: rtl/alu_defs.sv
// Shared opcode constants, instruction field layout and FSM state encoding for the ALU issue
// front end.
package alu_defs;

  localparam logic [2:0] OP_PASS2 = 3'd0;
  localparam logic [2:0] OP_PASS1 = 3'd1;
  localparam logic [2:0] OP_ADD   = 3'd2;
  localparam logic [2:0] OP_MUL   = 3'd3;
  localparam logic [2:0] OP_EQ    = 3'd4;
  localparam logic [2:0] OP_LT    = 3'd5;
  localparam logic [2:0] OP_NEG   = 3'd6;
  localparam logic [2:0] OP_ILL   = 3'd7;

  localparam int unsigned OP_LSB      = 29;
  localparam int unsigned RD_LSB      = 26;
  localparam int unsigned RS1_LSB     = 23;
  localparam int unsigned RS2_LSB     = 20;
  localparam int unsigned IMM_SEL_BIT = 19;
  localparam int unsigned RSVD_LSB    = 16;
  localparam int unsigned IMM_LSB     = 0;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StExec,
    StWb
  } state_e;

endpackage

// File: rtl/alu_regfile.sv
// NREGS x DW register file: one synchronous write port, two operand read ports and a debug
// read port, all combinational; r0 always reads zero.
module alu_regfile #(
  parameter int unsigned DW    = 32,
  parameter int unsigned NREGS = 8,
  parameter int unsigned AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr1,
  output logic [DW-1:0] rdata1,
  input  logic [AW-1:0] raddr2,
  output logic [DW-1:0] rdata2,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data
);

  logic [DW-1:0] mem [NREGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        mem[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata1   = (raddr1 == '0) ? '0 : mem[raddr1];
  assign rdata2   = (raddr2 == '0) ? '0 : mem[raddr2];
  assign dbg_data = (dbg_addr == '0) ? '0 : mem[dbg_addr];

endmodule

// File: rtl/alu_issue.sv
// Issue/sequencing front end for the external combinational ALU: accept, read operands,
// capture the ALU result, write it back. One instruction every four cycles.
module alu_issue
  import alu_defs::*;
#(
  parameter int unsigned DW    = 32,
  parameter int unsigned NREGS = 8,
  parameter int unsigned AW    = 3,
  parameter int unsigned IMMW  = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [31:0]   instr,
  output logic [2:0]    alu_op,
  output logic [DW-1:0] alu_in1,
  output logic [DW-1:0] alu_in2,
  input  logic [DW-1:0] alu_out,
  output logic          wb_valid,
  output logic [AW-1:0] wb_addr,
  output logic [DW-1:0] wb_data,
  output logic          illegal,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data
);

  state_e state_q, state_d;

  logic [2:0]      op_q;
  logic [AW-1:0]   rd_q, rs1_q, rs2_q;
  logic            imm_sel_q;
  logic [IMMW-1:0] imm_q;
  logic [2:0]      alu_op_q;
  logic [DW-1:0]   alu_in1_q, alu_in2_q, result_q;
  logic            illegal_q;

  logic [DW-1:0] rdata1, rdata2;
  logic          accept, accept_ill;
  logic [2:0]    instr_op;

  // Reserved instruction bits carry no meaning.
  logic unused_rsvd;
  assign unused_rsvd = ^instr[RSVD_LSB +: 3];

  assign instr_op    = instr[OP_LSB +: 3];
  assign instr_ready = (state_q == StIdle);
  assign accept      = instr_ready && instr_valid;
  assign accept_ill  = accept && (instr_op == OP_ILL);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept && !accept_ill) state_d = StRead;
      StRead:  state_d = StExec;
      StExec:  state_d = StWb;
      StWb:    state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      op_q      <= '0;
      rd_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      imm_sel_q <= 1'b0;
      imm_q     <= '0;
      alu_op_q  <= '0;
      alu_in1_q <= '0;
      alu_in2_q <= '0;
      result_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= accept_ill;
      if (accept && !accept_ill) begin
        op_q      <= instr_op;
        rd_q      <= instr[RD_LSB +: AW];
        rs1_q     <= instr[RS1_LSB +: AW];
        rs2_q     <= instr[RS2_LSB +: AW];
        imm_sel_q <= instr[IMM_SEL_BIT];
        imm_q     <= instr[IMM_LSB +: IMMW];
      end
      // ALU operands are only updated here and hold through EXEC, WB and IDLE.
      if (state_q == StRead) begin
        alu_op_q  <= op_q;
        alu_in1_q <= rdata1;
        alu_in2_q <= imm_sel_q ? {{(DW-IMMW){imm_q[IMMW-1]}}, imm_q} : rdata2;
      end
      if (state_q == StExec) begin
        result_q <= alu_out;
      end
    end
  end

  alu_regfile #(
    .DW    (DW),
    .NREGS (NREGS),
    .AW    (AW)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .we       (state_q == StWb),
    .waddr    (rd_q),
    .wdata    (result_q),
    .raddr1   (rs1_q),
    .rdata1   (rdata1),
    .raddr2   (rs2_q),
    .rdata2   (rdata2),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  assign alu_op   = alu_op_q;
  assign alu_in1  = alu_in1_q;
  assign alu_in2  = alu_in2_q;
  assign wb_valid = (state_q == StWb);
  assign wb_addr  = rd_q;
  assign wb_data  = result_q;
  assign illegal  = illegal_q;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue with a behavioural ALU driving alu_out and a
// register-file model for expected write-back values.
module tb_alu_issue;
  import alu_defs::*;

  logic        clk, rst, instr_valid, instr_ready;
  logic [31:0] instr;
  logic [2:0]  alu_op;
  logic [31:0] alu_in1, alu_in2, alu_out;
  logic        wb_valid, illegal;
  logic [2:0]  wb_addr, dbg_addr;
  logic [31:0] wb_data, dbg_data;

  int total = 0;
  int bad   = 0;
  logic [31:0] mdl [8];

  alu_issue dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .alu_op      (alu_op),
    .alu_in1     (alu_in1),
    .alu_in2     (alu_in2),
    .alu_out     (alu_out),
    .wb_valid    (wb_valid),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .illegal     (illegal),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_alu(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = 32'($signed(a[15:0]));
    sb = 32'($signed(b[15:0]));
    case (op)
      OP_PASS2: return b;
      OP_PASS1: return a;
      OP_ADD:   return a + b;
      OP_MUL:   return sa * sb;
      OP_EQ:    return {31'b0, a == b};
      OP_LT:    return {31'b0, $signed(a) < $signed(b)};
      OP_NEG:   return 32'd0 - b;
      default:  return 32'd0;
    endcase
  endfunction

  assign alu_out = ref_alu(alu_op, alu_in1, alu_in2);

  function automatic logic [31:0] mk(logic [2:0] op, logic [2:0] rd, logic [2:0] rs1,
                                     logic [2:0] rs2, logic sel, logic [2:0] rsvd,
                                     logic [15:0] imm);
    return {op, rd, rs1, rs2, sel, rsvd, imm};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!instr_ready && n < 10) begin
      step();
      n++;
    end
    if (!instr_ready) check("ready_timeout", {31'b0, instr_ready}, 32'd1);
  endtask

  // Issue one instruction and watch an 8-cycle window after the accepting edge.
  task automatic run_instr(input logic [31:0] w, output int pulses, output int lat,
                           output logic [2:0] addr, output logic [31:0] data);
    wait_ready();
    instr = w;
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    instr = $urandom;
    pulses = 0;
    lat = 0;
    addr = 3'd0;
    data = 32'd0;
    for (int n = 1; n <= 8; n++) begin
      if (wb_valid) begin
        if (pulses == 0) begin
          lat = n;
          addr = wb_addr;
          data = wb_data;
        end
        pulses++;
      end
      step();
    end
  endtask

  task automatic check_dbg(input string name, input logic [2:0] a, input logic [31:0] exp);
    dbg_addr = a;
    #1;
    check(name, dbg_data, exp);
  endtask

  typedef struct {
    logic [31:0] ins;
    logic [2:0]  rd;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[11];

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int pulses, lat, cnt_ready, cnt_acc, cnt_wb, pat_err;
    logic [2:0] addr;
    logic [31:0] data;

    vecs[0]  = '{mk(OP_PASS2, 3'd1, 3'd0, 3'd0, 1'b1, 3'd0, 16'd5), 3'd1, 32'd5};
    vecs[1]  = '{mk(OP_PASS2, 3'd2, 3'd0, 3'd0, 1'b1, 3'd0, 16'd7), 3'd2, 32'd7};
    vecs[2]  = '{mk(OP_ADD,   3'd3, 3'd1, 3'd2, 1'b0, 3'd5, 16'hBEEF), 3'd3, 32'd12};
    vecs[3]  = '{mk(OP_MUL,   3'd4, 3'd3, 3'd0, 1'b1, 3'd0, 16'hFFFD), 3'd4, 32'hFFFFFFDC};
    vecs[4]  = '{mk(OP_LT,    3'd5, 3'd4, 3'd1, 1'b0, 3'd0, 16'd0), 3'd5, 32'd1};
    vecs[5]  = '{mk(OP_EQ,    3'd5, 3'd1, 3'd2, 1'b0, 3'd0, 16'd0), 3'd5, 32'd0};
    vecs[6]  = '{mk(OP_NEG,   3'd6, 3'd0, 3'd1, 1'b0, 3'd0, 16'd0), 3'd6, 32'hFFFFFFFB};
    vecs[7]  = '{mk(OP_PASS2, 3'd0, 3'd0, 3'd0, 1'b1, 3'd0, 16'd9), 3'd0, 32'd9};
    vecs[8]  = '{mk(OP_PASS1, 3'd7, 3'd4, 3'd0, 1'b0, 3'd0, 16'd0), 3'd7, 32'hFFFFFFDC};
    vecs[9]  = '{mk(OP_PASS2, 3'd7, 3'd0, 3'd0, 1'b1, 3'd0, 16'h8000), 3'd7, 32'hFFFF8000};
    vecs[10] = '{mk(OP_NEG,   3'd1, 3'd0, 3'd0, 1'b1, 3'd0, 16'h8000), 3'd1, 32'h00008000};

    for (int i = 0; i < 8; i++) mdl[i] = 32'd0;
    rst = 1'b1;
    instr_valid = 1'b0;
    instr = 32'd0;
    dbg_addr = 3'd0;
    repeat (3) step();
    rst = 1'b0;

    check("reset_ready", {31'b0, instr_ready}, 32'd1);
    check("reset_wb_valid", {31'b0, wb_valid}, 32'd0);
    check("reset_illegal", {31'b0, illegal}, 32'd0);
    check("reset_alu_op", {29'b0, alu_op}, 32'd0);
    check("reset_alu_in1", alu_in1, 32'd0);
    check("reset_alu_in2", alu_in2, 32'd0);
    check("reset_wb_data", wb_data, 32'd0);
    check("reset_wb_addr", {29'b0, wb_addr}, 32'd0);
    for (int i = 1; i < 8; i++) check_dbg("reset_reg", 3'(i), 32'd0);

    for (int i = 0; i < 11; i++) begin
      run_instr(vecs[i].ins, pulses, lat, addr, data);
      check("dir_wb_pulses", pulses, 32'd1);
      check("dir_latency", lat, 32'd3);
      check("dir_wb_addr", {29'b0, addr}, {29'b0, vecs[i].rd});
      check("dir_wb_data", data, vecs[i].exp);
      if (vecs[i].rd != 3'd0) mdl[vecs[i].rd] = vecs[i].exp;
      check_dbg("dir_dbg", vecs[i].rd, mdl[vecs[i].rd]);
    end
    check("sext_alu_in2_hold", alu_in2, 32'hFFFF8000);

    // Illegal opcode: single pulse, stays ready, no write-back.
    wait_ready();
    instr = mk(OP_ILL, 3'd2, 3'd1, 3'd1, 1'b0, 3'd0, 16'd0);
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    check("ill_pulse", {31'b0, illegal}, 32'd1);
    check("ill_ready", {31'b0, instr_ready}, 32'd1);
    cnt_wb = 0;
    cnt_acc = 0;
    for (int n = 0; n < 6; n++) begin
      if (wb_valid) cnt_wb++;
      step();
      if (illegal) cnt_acc++;
    end
    check("ill_no_wb", cnt_wb, 32'd0);
    check("ill_single_pulse", cnt_acc, 32'd0);
    check_dbg("ill_r2_kept", 3'd2, mdl[2]);

    // Back-to-back with instr_valid held high (R3 <- R3 keeps state unchanged).
    wait_ready();
    instr = mk(OP_PASS1, 3'd3, 3'd3, 3'd0, 1'b0, 3'd0, 16'd0);
    instr_valid = 1'b1;
    cnt_ready = 0;
    cnt_acc = 0;
    cnt_wb = 0;
    pat_err = 0;
    for (int n = 0; n < 40; n++) begin
      if (instr_ready) begin
        cnt_ready++;
        cnt_acc++;
      end
      if (instr_ready != (n % 4 == 0)) pat_err++;
      if (wb_valid) cnt_wb++;
      step();
    end
    instr_valid = 1'b0;
    for (int n = 0; n < 6; n++) begin
      if (wb_valid) cnt_wb++;
      step();
    end
    check("tp_ready_count", cnt_ready, 32'd10);
    check("tp_ready_pattern_errs", pat_err, 32'd0);
    check("tp_wb_eq_accepts", cnt_wb, cnt_acc);
    check_dbg("tp_r3", 3'd3, mdl[3]);

    // Randomized instructions against the register-file model.
    for (int t = 0; t < 80; t++) begin
      logic [2:0] op, rd, rs1, rs2;
      logic sel;
      logic [15:0] imm;
      logic [31:0] b, exp;
      op  = ($urandom_range(0, 9) == 0) ? OP_ILL : 3'($urandom_range(0, 6));
      rd  = 3'($urandom);
      rs1 = 3'($urandom);
      rs2 = 3'($urandom);
      sel = 1'($urandom);
      imm = ($urandom_range(0, 3) == 0) ? 16'h8000 : 16'($urandom);
      b   = sel ? {{16{imm[15]}}, imm} : mdl[rs2];
      exp = ref_alu(op, mdl[rs1], b);
      run_instr(mk(op, rd, rs1, rs2, sel, 3'($urandom), imm), pulses, lat, addr, data);
      if (op == OP_ILL) begin
        check("rnd_ill_no_wb", pulses, 32'd0);
      end else begin
        check("rnd_wb_pulses", pulses, 32'd1);
        check("rnd_latency", lat, 32'd3);
        check("rnd_wb_addr", {29'b0, addr}, {29'b0, rd});
        check("rnd_wb_data", data, exp);
        check("rnd_alu_op_hold", {29'b0, alu_op}, {29'b0, op});
        check("rnd_alu_in2_hold", alu_in2, b);
        if (rd != 3'd0) mdl[rd] = exp;
      end
      rs1 = 3'($urandom);
      check_dbg("rnd_dbg", rs1, mdl[rs1]);
    end

    // Reset during EXEC aborts the instruction.
    wait_ready();
    instr = mk(OP_PASS2, 3'd7, 3'd0, 3'd0, 1'b1, 3'd0, 16'h1234);
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_mid_ready", {31'b0, instr_ready}, 32'd1);
    cnt_wb = 0;
    for (int n = 0; n < 6; n++) begin
      if (wb_valid) cnt_wb++;
      step();
    end
    check("rst_mid_no_wb", cnt_wb, 32'd0);
    for (int i = 1; i < 8; i++) check_dbg("rst_mid_reg", 3'(i), 32'd0);
    check("rst_mid_alu_in1", alu_in1, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
